// File: rtl/stim_pkg.sv
// Shared types and constants for the opcode stimulus player.
// Opcode layout: [7]=obs, [6]=stbi, [5:0]=x_in.
package stim_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } stim_state_e;

    localparam int OBS_BIT    = 7;
    localparam int STBI_BIT   = 6;
    localparam int X_LSB      = 0;
    localparam int X_MSB      = 5;
    localparam int STIM_DEPTH = 11;

    // A run length is playable when it is non-empty and fits the store.
    function automatic logic len_fits(input int l, input int depth);
        return (l >= 1) && (l <= depth);
    endfunction

endpackage

// File: rtl/stim_opcode_ram.sv
// Opcode program store: register array, one synchronous write
// port, one asynchronous read port. Contents are never reset.
module stim_opcode_ram
    import stim_pkg::*;
#(
    parameter int DEPTH = STIM_DEPTH,
    parameter int OP_W  = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clock,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [OP_W-1:0] wdata,
    input  logic [AW-1:0]   raddr,
    output logic [OP_W-1:0] rdata
);

    logic [OP_W-1:0] mem [DEPTH];

    logic waddr_ok;
    logic raddr_ok;

    assign waddr_ok = (int'(waddr) < DEPTH);
    assign raddr_ok = (int'(raddr) < DEPTH);

    // Write only addresses that exist; out-of-range writes vanish.
    always_ff @(posedge clock) begin
        if (we && waddr_ok) begin
            mem[waddr] <= wdata;
        end
    end

    // Out-of-range reads return an all-zero opcode.
    always_comb begin
        rdata = '0;
        if (raddr_ok) begin
            rdata = mem[raddr];
        end
    end

endmodule

// File: rtl/stim_opcode_player.sv
// Opcode stimulus sequencer: plays a stored program one opcode
// per clock and decodes it onto the b11 inputs x_in/stbi/obs.
module stim_opcode_player
    import stim_pkg::*;
#(
    parameter int DEPTH = STIM_DEPTH,
    parameter int OP_W  = 8,
    parameter int X_W   = 6,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            load_en,
    input  logic [AW-1:0]   load_addr,
    input  logic [OP_W-1:0] load_data,
    input  logic            start,
    input  logic [AW:0]     len,
    input  logic            loop_en,
    input  logic            hold,
    input  logic            stop,
    output logic [X_W-1:0]  x_in,
    output logic            stbi,
    output logic            obs,
    output logic            valid,
    output logic            busy,
    output logic            done,
    output logic            cfg_err,
    output logic [AW-1:0]   pc,
    output logic [7:0]      loop_cnt
);

    stim_state_e state_q;
    stim_state_e state_d;

    // pc carries one extra bit so it can park at len_q
    // (one past the last opcode) while the run winds down.
    logic [AW:0]     pc_q;
    logic [AW:0]     len_q;
    logic            loop_q;
    logic [OP_W-1:0] rd_op;

    logic len_ok;
    logic last_op;
    logic at_end;
    logic ram_we;
    logic accept;
    logic reject;
    logic issue;
    logic clear;

    assign len_ok  = len_fits(int'(len), DEPTH);
    assign last_op = (pc_q == (len_q - 1'b1));
    assign at_end  = (pc_q == len_q);
    assign ram_we  = load_en && (state_q != RUN);

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign pc   = pc_q[AW-1:0];

    stim_opcode_ram #(
        .DEPTH (DEPTH),
        .OP_W  (OP_W),
        .AW    (AW)
    ) u_ram (
        .clock (clock),
        .we    (ram_we),
        .waddr (load_addr),
        .wdata (load_data),
        .raddr (pc_q[AW-1:0]),
        .rdata (rd_op)
    );

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-edge datapath strobes; stop beats
    // start and hold, and a finished run leaves via DONE.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        reject  = 1'b0;
        issue   = 1'b0;
        clear   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    if (len_ok) begin
                        accept  = 1'b1;
                        state_d = RUN;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            RUN: begin
                if (stop) begin
                    clear   = 1'b1;
                    state_d = IDLE;
                end else if (at_end) begin
                    state_d = DONE;
                end else if (!hold) begin
                    issue = 1'b1;
                end
            end
            DONE: begin
                clear   = 1'b1;
                state_d = IDLE;
            end
            default: begin
                clear   = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    // Run configuration latched once at accept time.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            len_q  <= '0;
            loop_q <= 1'b0;
        end else if (accept) begin
            len_q  <= len;
            loop_q <= loop_en;
        end
    end

    // Program counter and loop pass counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q     <= '0;
            loop_cnt <= '0;
        end else if (accept || clear) begin
            pc_q     <= '0;
            loop_cnt <= '0;
        end else if (issue) begin
            if (last_op && loop_q) begin
                pc_q <= '0;
                if (loop_cnt != 8'hFF) begin
                    loop_cnt <= loop_cnt + 8'd1;
                end
            end else begin
                pc_q <= pc_q + 1'b1;
            end
        end
    end

    // Registered decode of the issued opcode plus status pulses.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            x_in    <= '0;
            stbi    <= 1'b0;
            obs     <= 1'b0;
            valid   <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            valid   <= issue;
            cfg_err <= reject;
            if (clear) begin
                x_in <= '0;
                stbi <= 1'b0;
                obs  <= 1'b0;
            end else if (issue) begin
                x_in <= rd_op[X_LSB +: X_W];
                stbi <= rd_op[STBI_BIT];
                obs  <= rd_op[OBS_BIT];
            end
        end
    end

endmodule

// File: tb/tb_stim_opcode_player.sv
// Directed bench for stim_opcode_player: vector table for plain
// runs and config errors, hand sequences for the multi-cycle cases.
module tb_stim_opcode_player;

    localparam int DEPTH = 11;
    localparam int AW    = 4;

    logic          clock;
    logic          reset;
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [7:0]    load_data;
    logic          start;
    logic [AW:0]   len;
    logic          loop_en;
    logic          hold;
    logic          stop;
    logic [5:0]    x_in;
    logic          stbi;
    logic          obs;
    logic          valid;
    logic          busy;
    logic          done;
    logic          cfg_err;
    logic [AW-1:0] pc;
    logic [7:0]    loop_cnt;

    int tests = 0;
    int fails = 0;
    int nbusy = 0;

    logic [7:0] prog [DEPTH];

    typedef struct {
        logic       start;
        logic [4:0] len;
        logic       stop;
        logic [5:0] x;
        logic       valid;
        logic       busy;
        logic       done;
        logic       cfg_err;
        logic [3:0] pc;
    } vec_t;

    vec_t vecs[$];

    stim_opcode_player dut (
        .clock     (clock),
        .reset     (reset),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .start     (start),
        .len       (len),
        .loop_en   (loop_en),
        .hold      (hold),
        .stop      (stop),
        .x_in      (x_in),
        .stbi      (stbi),
        .obs       (obs),
        .valid     (valid),
        .busy      (busy),
        .done      (done),
        .cfg_err   (cfg_err),
        .pc        (pc),
        .loop_cnt  (loop_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        if (busy) nbusy++;
    endtask

    task automatic load(input int a, input logic [7:0] d);
        load_en   = 1'b1;
        load_addr = AW'(a);
        load_data = d;
        tick();
        load_en = 1'b0;
    endtask

    task automatic add(input logic s, input logic [4:0] l,
                       input logic st, input logic [5:0] x,
                       input logic v, input logic b,
                       input logic d, input logic ce,
                       input logic [3:0] p);
        vec_t t;
        t.start = s; t.len = l; t.stop = st; t.x = x;
        t.valid = v; t.busy = b; t.done = d;
        t.cfg_err = ce; t.pc = p;
        vecs.push_back(t);
    endtask

    // Expected decode {x_in, stbi, obs} of an opcode.
    function automatic logic [7:0] dec(input logic [7:0] op);
        return {op[5:0], op[6], op[7]};
    endfunction

    // Full non-loop replay of the model program, len = 11.
    task automatic replay(input string tag);
        start = 1'b1; len = 5'd11; loop_en = 1'b0;
        tick();
        start = 1'b0;
        chk({tag, "_start"}, {busy, valid, pc}, {1'b1, 1'b0, 4'd0});
        for (int k = 0; k < DEPTH; k++) begin
            tick();
            chk($sformatf("%s_op%0d", tag, k),
                {x_in, stbi, obs, valid, pc},
                {dec(prog[k]), 1'b1, 4'(k + 1)});
        end
        tick();
        chk({tag, "_done"}, {done, valid, busy}, 3'b101);
        tick();
        chk({tag, "_idle"}, {x_in, stbi, obs, valid, busy, done},
            '0);
    endtask

    initial begin
        reset = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
        start = 1'b0; len = '0; loop_en = 1'b0; hold = 1'b0; stop = 1'b0;

        // Table: straight run of 0x00..0x0A, then config errors.
        add(1, 11, 0, 0, 0, 1, 0, 0, 0);
        for (int k = 1; k <= 11; k++)
            add(0, 0, 0, 6'(k - 1), 1, 1, 0, 0, 4'(k));
        add(0, 0, 0, 10, 0, 1, 1, 0, 11);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 12, 0, 0, 0, 0, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 3, 1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 1, 0, 0, 0, 0, 0, 0);
        add(1, 31, 0, 0, 0, 0, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0);

        tick();
        tick();
        chk("reset_outs",
            {x_in, stbi, obs, valid, busy, done, cfg_err, pc, loop_cnt},
            '0);
        @(negedge clock);
        reset = 1'b1;
        tick();

        for (int k = 0; k < DEPTH; k++) load(k, 8'(k));

        foreach (vecs[i]) begin
            start = vecs[i].start;
            len   = vecs[i].len;
            stop  = vecs[i].stop;
            tick();
            chk($sformatf("vec%0d", i),
                {x_in, stbi, obs, valid, busy, done, cfg_err, pc},
                {vecs[i].x, 2'b00, vecs[i].valid, vecs[i].busy,
                 vecs[i].done, vecs[i].cfg_err, vecs[i].pc});
        end
        start = 1'b0; len = '0; stop = 1'b0;

        // Loop mode over two opcodes.
        load(0, 8'hC5);
        load(1, 8'h3F);
        start = 1'b1; len = 5'd2; loop_en = 1'b1;
        tick();
        start = 1'b0; loop_en = 1'b0;
        for (int p = 1; p <= 3; p++) begin
            tick();
            chk($sformatf("loop%0d_a", p),
                {x_in, stbi, obs, valid, done, pc, loop_cnt},
                {6'd5, 1'b1, 1'b1, 1'b1, 1'b0, 4'd1, 8'(p - 1)});
            tick();
            chk($sformatf("loop%0d_b", p),
                {x_in, stbi, obs, valid, done, pc, loop_cnt},
                {6'd63, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 8'(p)});
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("loop_stop", {x_in, stbi, obs, valid, busy, done, pc}, '0);

        // New program with obs/stbi bits mixed in.
        for (int k = 0; k < DEPTH; k++) begin
            prog[k] = 8'((k * 7 + 3) % 64);
            if (k % 2 == 1) prog[k][7] = 1'b1;
            if (k % 3 == 0) prog[k][6] = 1'b1;
            load(k, prog[k]);
        end

        // Hold for three cycles at pc=4.
        nbusy = 0;
        start = 1'b1; len = 5'd11;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        chk("pre_hold", {x_in, stbi, obs, valid, pc},
            {dec(prog[3]), 1'b1, 4'd4});
        hold = 1'b1;
        for (int h = 0; h < 3; h++) begin
            tick();
            chk($sformatf("hold%0d", h), {x_in, stbi, obs, valid, pc},
                {dec(prog[3]), 1'b0, 4'd4});
        end
        hold = 1'b0;
        for (int k = 4; k < DEPTH; k++) begin
            tick();
            chk($sformatf("resume%0d", k), {x_in, stbi, obs, valid, pc},
                {dec(prog[k]), 1'b1, 4'(k + 1)});
        end
        tick();
        chk("hold_done", {done, valid, x_in},
            {1'b1, 1'b0, prog[10][5:0]});
        tick();
        chk("hold_idle", {busy, done, x_in}, '0);
        chk("hold_len", nbusy, 16);

        // Mid-run load ignored, then stop together with hold at pc=6.
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        load(3, ~prog[3]);
        for (int k = 0; k < 3; k++) tick();
        chk("pre_stop", {pc, valid}, {4'd6, 1'b1});
        stop = 1'b1; hold = 1'b1;
        tick();
        stop = 1'b0; hold = 1'b0;
        chk("stop_outs", {x_in, stbi, obs, valid, busy, done, pc}, '0);
        tick();
        chk("stop_nodone", {done, busy}, 2'b00);
        replay("rp5");

        // Asynchronous reset mid-run at pc=5.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        chk("pre_reset", {pc, busy}, {4'd5, 1'b1});
        #2;
        reset = 1'b0;
        #1;
        chk("async_reset",
            {x_in, stbi, obs, valid, busy, done, cfg_err, pc, loop_cnt},
            '0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        tick();
        replay("rp6");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
